axi4lite_reg_bank: RTL and testbench

- Parametrised AXI4-Lite slave holding NUM_REGS read/write registers of DATA_WIDTH bits.
- Adds over the single-register slave: address decode, per-byte write strobes, SLVERR on unmapped addresses, a per-register write-pulse output, and optional pipeline stages on each path.
- Sits between the interconnect and control logic; register contents drive reg_o directly.

---
 rtl/axi4lite_reg_bank.sv | 195 +++++++++++++++++++
 tb/tb_axi4lite_reg_bank.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_reg_bank.sv
// axi4lite_reg_bank: AXI4-Lite slave with NUM_REGS byte-strobed registers, SLVERR decode and optional pipe stages
module axi4lite_reg_bank #(
    parameter int NUM_REGS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int PIPE_WR = 1,
    parameter int PIPE_RD = 1
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic [2:0]                     awprot,
    input  logic                           wvalid,
    output logic                           wready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    output logic                           bvalid,
    input  logic                           bready,
    output logic [1:0]                     bresp,
    input  logic                           arvalid,
    output logic                           arready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic [2:0]                     arprot,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
    output logic [NUM_REGS-1:0]            reg_wr_o
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(NB);
    localparam logic [31:0] NR = 32'(NUM_REGS);

    logic                           aw_have_q, aw_have_d, w_have_q, w_have_d;
    logic [ADDR_WIDTH-1:0]          awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
    logic [NB-1:0]                  wstrb_q, wstrb_d;
    logic                           wreq_q, wreq_d;
    logic                           wp_req_q, wp_req_d;
    logic [31:0]                    wp_idx_q, wp_idx_d;
    logic [DATA_WIDTH-1:0]          wp_data_q, wp_data_d;
    logic [NB-1:0]                  wp_strb_q, wp_strb_d;
    logic [NUM_REGS*DATA_WIDTH-1:0] reg_q, reg_d;
    logic [NUM_REGS-1:0]            reg_wr_q, reg_wr_d;
    logic                           bvalid_q, bvalid_d;
    logic [1:0]                     bresp_q, bresp_d;
    logic                           ar_busy_q, ar_busy_d;
    logic [ADDR_WIDTH-1:0]          araddr_q, araddr_d;
    logic                           rreq_q, rreq_d;
    logic                           rp_req_q, rp_req_d;
    logic [DATA_WIDTH-1:0]          rp_data_q, rp_data_d;
    logic                           rp_err_q, rp_err_d;
    logic                           rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
    logic [1:0]                     rresp_q, rresp_d;

    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_fire;
    logic [31:0]           w1_idx, u_idx, r1_idx;
    logic                  u_req, u_map, r1_err, rs_req, rs_err;
    logic [DATA_WIDTH-1:0] u_data, r1_val, rs_data;
    logic [NB-1:0]         u_strb;
    logic                  unused_prot;

    assign unused_prot = ^{awprot, arprot};

    assign awready = ~aw_have_q;
    assign wready  = ~w_have_q;
    assign arready = ~ar_busy_q;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign b_hs    = bvalid_q & bready;
    assign ar_hs   = arvalid & arready;
    assign r_hs    = rvalid_q & rready;
    // the later of the AW/W handshakes completes the pair; one pulse per write
    assign wr_fire = (aw_hs | w_hs) & (aw_have_q | aw_hs) & (w_have_q | w_hs);

    assign w1_idx  = 32'(awaddr_q >> SHIFT);
    assign u_req   = (PIPE_WR != 0) ? wp_req_q  : wreq_q;
    assign u_idx   = (PIPE_WR != 0) ? wp_idx_q  : w1_idx;
    assign u_data  = (PIPE_WR != 0) ? wp_data_q : wdata_q;
    assign u_strb  = (PIPE_WR != 0) ? wp_strb_q : wstrb_q;
    assign u_map   = u_idx < NR;

    assign r1_idx  = 32'(araddr_q >> SHIFT);
    assign r1_err  = ~(r1_idx < NR);
    assign rs_req  = (PIPE_RD != 0) ? rp_req_q  : rreq_q;
    assign rs_data = (PIPE_RD != 0) ? rp_data_q : r1_val;
    assign rs_err  = (PIPE_RD != 0) ? rp_err_q  : r1_err;

    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;
    assign reg_o    = reg_q;
    assign reg_wr_o = reg_wr_q;

    // read mux: unmapped indices fall through to zero
    always_comb begin
        r1_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (r1_idx == i) r1_val = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // next-state for both channels, pipe stages and the byte-merged register file
    always_comb begin
        aw_have_d = b_hs ? 1'b0 : (aw_have_q | aw_hs);
        w_have_d  = b_hs ? 1'b0 : (w_have_q | w_hs);
        awaddr_d  = aw_hs ? awaddr : awaddr_q;
        wdata_d   = w_hs ? wdata : wdata_q;
        wstrb_d   = w_hs ? wstrb : wstrb_q;
        wreq_d    = wr_fire;
        wp_req_d  = wreq_q;
        wp_idx_d  = w1_idx;
        wp_data_d = wdata_q;
        wp_strb_d = wstrb_q;
        reg_d     = reg_q;
        reg_wr_d  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (u_req && u_idx == i) begin
                reg_wr_d[i] = 1'b1;
                for (int k = 0; k < NB; k++)
                    if (u_strb[k]) reg_d[i*DATA_WIDTH + k*8 +: 8] = u_data[k*8 +: 8];
            end
        end
        bvalid_d  = u_req ? 1'b1 : (b_hs ? 1'b0 : bvalid_q);
        bresp_d   = u_req ? (u_map ? 2'b00 : 2'b10) : bresp_q;
        ar_busy_d = r_hs ? 1'b0 : (ar_busy_q | ar_hs);
        araddr_d  = ar_hs ? araddr : araddr_q;
        rreq_d    = ar_hs;
        rp_req_d  = rreq_q;
        rp_data_d = r1_val;
        rp_err_d  = r1_err;
        rvalid_d  = rs_req ? 1'b1 : (r_hs ? 1'b0 : rvalid_q);
        rdata_d   = rs_req ? rs_data : rdata_q;
        rresp_d   = rs_req ? (rs_err ? 2'b10 : 2'b00) : rresp_q;
    end

    // state registers; reset drops any in-flight transaction
    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wreq_q    <= 1'b0;
            wp_req_q  <= 1'b0;
            wp_idx_q  <= '0;
            wp_data_q <= '0;
            wp_strb_q <= '0;
            reg_q     <= RESET_VALUE;
            reg_wr_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            ar_busy_q <= 1'b0;
            araddr_q  <= '0;
            rreq_q    <= 1'b0;
            rp_req_q  <= 1'b0;
            rp_data_q <= '0;
            rp_err_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wreq_q    <= wreq_d;
            wp_req_q  <= wp_req_d;
            wp_idx_q  <= wp_idx_d;
            wp_data_q <= wp_data_d;
            wp_strb_q <= wp_strb_d;
            reg_q     <= reg_d;
            reg_wr_q  <= reg_wr_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            ar_busy_q <= ar_busy_d;
            araddr_q  <= araddr_d;
            rreq_q    <= rreq_d;
            rp_req_q  <= rp_req_d;
            rp_data_q <= rp_data_d;
            rp_err_q  <= rp_err_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end
endmodule

// File: tb/tb_axi4lite_reg_bank.sv
// tb_axi4lite_reg_bank: directed checks of decode, strobes, SLVERR, latency, hazards, backpressure and reset
module tb_axi4lite_reg_bank;
    localparam logic [127:0] RV = {32'h0, 32'h0, 32'h12345678, 32'h0};

    logic aclk = 1'b0, areset = 1'b1;
    logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [7:0] awaddr = 0, araddr = 0;
    logic [31:0] wdata = 0, rdata;
    logic [3:0] wstrb = 0, reg_wr_o, last_wr = 0;
    logic [1:0] bresp, rresp, resp;
    logic [127:0] reg_o, snap;
    logic [31:0] data;
    logic bv_prev = 0;
    int n_cmp = 0, n_err = 0, wr_pulses = 0, bv_rises = 0, lat, p0, b0;

    axi4lite_reg_bank #(.NUM_REGS(4), .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESET_VALUE(RV),
                        .PIPE_WR(1), .PIPE_RD(1)) dut (
        .aclk(aclk), .areset(areset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(3'b000),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(3'b000),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .reg_o(reg_o), .reg_wr_o(reg_wr_o)
    );

    always #5 aclk = ~aclk;

    // counts pulse cycles and bvalid rising edges
    always @(posedge aclk) begin
        if (|reg_wr_o) begin
            wr_pulses <= wr_pulses + 1;
            last_wr <= reg_wr_o;
        end
        bv_prev <= bvalid;
        if (bvalid && !bv_prev) bv_rises <= bv_rises + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] r, output int l);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        l = 1;
        while (!bvalid && l < 20) begin tick(); l++; end
        r = bresp;
        bready = 1;
        tick();
        bready = 0;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r,
                           output int l);
        araddr = a; arvalid = 1;
        tick();
        arvalid = 0;
        l = 1;
        while (!rvalid && l < 20) begin tick(); l++; end
        d = rdata; r = rresp;
        rready = 1;
        tick();
        rready = 0;
    endtask

    initial begin
        tick(); tick();
        areset = 0;
        check("rst_valid", {bvalid, rvalid}, 2'b00);
        check("rst_ready", {awready, wready, arready}, 3'b111);
        check("rst_regwr", reg_wr_o, 4'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_resp", {bresp, rresp}, 4'b0);
        check("rst_reg_o", reg_o, RV);

        do_read(8'h04, data, resp, lat);
        check("rd_rst_data", data, 32'h12345678);
        check("rd_rst_resp", resp, 2'b00);
        check("rd_lat", lat, 3);

        p0 = wr_pulses;
        do_write(8'h08, 32'hDEADBEEF, 4'b0101, resp, lat);
        check("strb_resp", resp, 2'b00);
        check("strb_lat", lat, 3);
        check("strb_reg2", reg_o[95:64], 32'h00AD00EF);
        check("strb_pulses", wr_pulses - p0, 1);
        check("strb_which", last_wr, 4'b0100);
        check("strb_rdy_back", {awready, wready}, 2'b11);

        p0 = wr_pulses; b0 = bv_rises;
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1;
        tick();
        wvalid = 0;
        check("wfirst_rdy", {awready, wready}, 2'b10);
        tick(); tick();
        check("wfirst_nob", bvalid, 1'b0);
        awaddr = 8'h0C; awvalid = 1;
        tick();
        awvalid = 0;
        lat = 1;
        while (!bvalid && lat < 20) begin tick(); lat++; end
        check("wfirst_lat", lat, 3);
        check("wfirst_regs", reg_o, {32'hCAFEF00D, 32'h00AD00EF, 32'h12345678, 32'h0});
        bready = 1; tick(); bready = 0;
        tick(); tick(); tick();
        check("wfirst_pulses", wr_pulses - p0, 1);
        check("wfirst_which", last_wr, 4'b1000);
        check("wfirst_bonce", bv_rises - b0, 1);

        snap = reg_o; p0 = wr_pulses;
        do_write(8'h40, 32'h55555555, 4'hF, resp, lat);
        check("unm_bresp", resp, 2'b10);
        check("unm_pulses", wr_pulses - p0, 0);
        check("unm_regs", reg_o, snap);
        do_read(8'h40, data, resp, lat);
        check("unm_rdata", data, 32'h0);
        check("unm_rresp", resp, 2'b10);

        do_write(8'h00, 32'h1, 4'hF, resp, lat);
        awaddr = 8'h00; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; araddr = 8'h00; arvalid = 1;
        tick();
        arvalid = 0;
        lat = 0;
        while (!rvalid && lat < 20) begin tick(); lat++; end
        check("haz_rdata", rdata, 32'h1);
        check("haz_bvalid", bvalid, 1'b1);
        bready = 1; rready = 1; tick(); bready = 0; rready = 0;
        check("haz_reg0", reg_o[31:0], 32'h2);
        do_read(8'h00, data, resp, lat);
        check("haz_reread", data, 32'h2);

        p0 = wr_pulses;
        awaddr = 8'h04; wdata = 32'hA5A5A5A5; wstrb = 4'hF; araddr = 8'h0C;
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        repeat (10) tick();
        check("bp_valids", {bvalid, rvalid}, 2'b11);
        check("bp_rdata", rdata, 32'hCAFEF00D);
        check("bp_pulses", wr_pulses - p0, 1);
        check("bp_readys", {awready, arready}, 2'b00);
        check("bp_reg1", reg_o[63:32], 32'hA5A5A5A5);
        bready = 1; rready = 1; tick(); bready = 0; rready = 0;
        check("bp_done", {bvalid, rvalid}, 2'b00);
        check("bp_rdy_back", {awready, arready}, 2'b11);

        p0 = wr_pulses;
        awaddr = 8'h08; wdata = 32'hFFFFFFFF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; areset = 1;
        tick();
        areset = 0;
        check("mrst_bvalid", bvalid, 1'b0);
        check("mrst_regs", reg_o, RV);
        check("mrst_ready", {awready, wready, arready}, 3'b111);
        repeat (5) tick();
        check("mrst_quiet", {bvalid, 3'b000}, 4'b0);
        check("mrst_pulses", wr_pulses - p0, 0);
        check("mrst_regs2", reg_o, RV);
        do_write(8'h08, 32'h11223344, 4'hF, resp, lat);
        check("post_resp", resp, 2'b00);
        check("post_lat", lat, 3);
        check("post_reg2", reg_o[95:64], 32'h11223344);
        check("post_pulses", wr_pulses - p0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
